// File: rtl/cordic_addsub_pipe_pkg.sv
// Shared definitions for the CORDIC add/sub pipeline: op encodings and the
// saturation helper used by the combinational front end.
package cordic_alu_pkg;

  localparam logic [1:0] OP_ADD     = 2'd0;
  localparam logic [1:0] OP_SUB     = 2'd1;
  localparam logic [1:0] OP_ADD_SHR = 2'd2;
  localparam logic [1:0] OP_SUB_SHR = 2'd3;

  // Widest word the clamp helper supports; callers sign-extend into it.
  localparam int MAX_W = 64;

  // Clamp a (width+1)-bit extended sum, sign-extended to MAX_W+1 bits, to the
  // signed range of a width-bit word. Bits at and above width-1 follow the
  // sum's true sign on overflow; the bits below take the opposite value.
  function automatic logic [MAX_W-1:0] sat_clamp(input logic [MAX_W:0] sum,
                                                 input int width);
    logic [MAX_W-1:0] res;
    res = sum[MAX_W-1:0];
    if (sum[width] != sum[width-1]) begin
      for (int i = 0; i < MAX_W; i++) begin
        res[i] = (i < width - 1) ? ~sum[width] : sum[width];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cordic_addsub_pipe_stage.sv
// One valid/ready register slice. It loads whenever it is empty or its
// downstream neighbour is taking its current contents.
module alu_pipe_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 load,
  input  logic                 dn_load,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] data
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;

  always_comb begin
    // NOTE: hold values are assigned first so no path leaves a signal unassigned (no latch).
    valid_d = valid_q;
    data_d  = data_q;
    load    = !valid_q || dn_load;
    if (load) begin
      valid_d = up_valid;
      data_d  = up_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too, purely so outputs read zero after reset.
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every slice samples its neighbour's pre-edge value.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/cordic_addsub_pipe.sv
// Pipelined add/sub with CORDIC shift-add modes, optional saturation and
// valid/ready flow control. Arithmetic sits ahead of the first register slice.
module cordic_addsub_pipe
  import cordic_alu_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 4,
  parameter int PIPE_STAGES = 2,
  parameter int SATURATE    = 1,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [WORD_WIDTH-1:0]  a,
  input  logic [WORD_WIDTH-1:0]  b,
  input  logic [TAG_WIDTH-1:0]   tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  result,
  output logic                   overflow,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam int W  = WORD_WIDTH;
  localparam int PW = W + TAG_WIDTH + 1;

  logic [31:0]    shift_ext;
  logic [W-1:0]   b_op;
  logic [W:0]     a_ext, b_ext, sum_ext;
  logic [MAX_W-1:0] clamp_full;
  logic [W-1:0]   res_word;
  logic           ovf;
  logic           is_sub, is_shr;

  always_comb begin
    is_sub    = (op == OP_SUB) || (op == OP_SUB_SHR);
    is_shr    = (op == OP_ADD_SHR) || (op == OP_SUB_SHR);
    shift_ext = 32'(shift);
    b_op      = b;
    if (is_shr) begin
      // Shifts of a full word or more leave only sign bits.
      if (shift_ext >= 32'(W)) b_op = {W{b[W-1]}};
      else                     b_op = $signed(b) >>> shift;
    end
    a_ext = {a[W-1], a};
    b_ext = {b_op[W-1], b_op};
    if (is_sub) sum_ext = a_ext + ~b_ext + (W+1)'(1);
    else        sum_ext = a_ext + b_ext;
    ovf        = sum_ext[W] ^ sum_ext[W-1];
    clamp_full = sat_clamp({{(MAX_W-W){sum_ext[W]}}, sum_ext}, W);
    res_word   = (SATURATE != 0) ? clamp_full[W-1:0] : sum_ext[W-1:0];
  end

  // Index 0 is the front end feeding stage 1; index PIPE_STAGES is the output.
  logic          vld [PIPE_STAGES+1];
  logic [PW-1:0] dat [PIPE_STAGES+1];
  logic          ld  [PIPE_STAGES+1];

  assign vld[0]          = in_valid;
  assign dat[0]          = {ovf, tag, res_word};
  assign ld[PIPE_STAGES] = out_ready;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    alu_pipe_stage #(
      .PAYLOAD_W(PW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (vld[i]),
      .up_data  (dat[i]),
      .load     (ld[i]),
      .dn_load  (ld[i+1]),
      .valid    (vld[i+1]),
      .data     (dat[i+1])
    );
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[PIPE_STAGES];
  assign result    = dat[PIPE_STAGES][W-1:0];
  assign out_tag   = dat[PIPE_STAGES][W +: TAG_WIDTH];
  assign overflow  = dat[PIPE_STAGES][PW-1];

endmodule

// File: tb/tb_cordic_addsub_pipe.sv
// Scoreboard bench: a saturating and a wrapping instance share all inputs;
// expected results come from an integer reference model.
module tb_cordic_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = '0;
  logic [4:0]  shift = '0;
  logic [15:0] a = '0, b = '0;
  logic [3:0]  tag = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, overflow;
  logic [15:0] result;
  logic [3:0]  out_tag;
  logic        in_ready_w, out_valid_w, overflow_w;
  logic [15:0] result_w;
  logic [3:0]  out_tag_w;

  always #5 clk = ~clk;

  cordic_addsub_pipe #(
    .WORD_WIDTH(16), .SHIFT_WIDTH(5), .PIPE_STAGES(2), .SATURATE(1), .TAG_WIDTH(4)
  ) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .shift(shift), .a(a), .b(b), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .out_tag(out_tag)
  );

  cordic_addsub_pipe #(
    .WORD_WIDTH(16), .SHIFT_WIDTH(5), .PIPE_STAGES(2), .SATURATE(0), .TAG_WIDTH(4)
  ) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .op(op), .shift(shift), .a(a), .b(b), .tag(tag),
    .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
    .overflow(overflow_w), .out_tag(out_tag_w)
  );

  typedef struct {
    logic [15:0] res_sat;
    logic [15:0] res_wrap;
    logic        ovf;
    logic [3:0]  tg;
    int          hs_cyc;
    bit          lat_chk;
  } sb_item_t;

  sb_item_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  n_popped = 0;
  bit  saw_in_ready_low = 0;
  bit  stalled_prev = 0;
  bit  rnd_done = 0;
  logic [15:0] res_hold;
  logic [3:0]  tag_hold;
  logic        ovf_hold;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  function automatic sb_item_t model(input logic [1:0] o, input logic [4:0] sh,
                                     input logic [15:0] aa, input logic [15:0] bb,
                                     input logic [3:0] tg);
    sb_item_t it;
    int ai, bi, bsv, s;
    ai = $signed(aa);
    bi = $signed(bb);
    bsv = bi;
    if (o == 2'd2 || o == 2'd3) begin
      if (sh >= 5'd16) bsv = (bi < 0) ? -1 : 0;
      else             bsv = bi >>> sh;
    end
    s = (o == 2'd1 || o == 2'd3) ? ai - bsv : ai + bsv;
    it.ovf      = (s > 32767) || (s < -32768);
    it.res_wrap = s[15:0];
    if (s > 32767)       it.res_sat = 16'h7FFF;
    else if (s < -32768) it.res_sat = 16'h8000;
    else                 it.res_sat = s[15:0];
    it.tg      = tg;
    it.hs_cyc  = 0;
    it.lat_chk = 0;
    return it;
  endfunction

  // Entered and left at posedge+1; inputs stay valid for back-to-back sends.
  task automatic send(input logic [1:0] o, input logic [4:0] sh, input logic [15:0] aa,
                      input logic [15:0] bb, input logic [3:0] tg, input bit lat = 0);
    sb_item_t it;
    int n = 0;
    bit done = 0;
    in_valid = 1'b1; op = o; shift = sh; a = aa; b = bb; tag = tg;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        it = model(o, sh, aa, bb, tg);
        it.hs_cyc  = cyc;
        it.lat_chk = lat;
        sb.push_back(it);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 500) begin
        check("send_timeout", 32'(in_ready), 32'd1);
        done = 1;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: a transfer is certain at the next edge when seen here.
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled_prev = 0;
      end else begin
        if (!in_ready) saw_in_ready_low = 1;
        if (out_valid && !out_ready) begin
          if (stalled_prev) begin
            check("stall_result", 32'(result), 32'(res_hold));
            check("stall_tag", 32'(out_tag), 32'(tag_hold));
            check("stall_ovf", 32'(overflow), 32'(ovf_hold));
          end
          res_hold = result; tag_hold = out_tag; ovf_hold = overflow;
          stalled_prev = 1;
        end else begin
          stalled_prev = 0;
        end
        if (out_valid && out_ready) begin
          check("out_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            it = sb.pop_front();
            n_popped++;
            check("result_sat", 32'(result), 32'(it.res_sat));
            check("ovf_sat", 32'(overflow), 32'(it.ovf));
            check("tag", 32'(out_tag), 32'(it.tg));
            check("wrap_valid", 32'(out_valid_w), 32'd1);
            check("result_wrap", 32'(result_w), 32'(it.res_wrap));
            check("ovf_wrap", 32'(overflow_w), 32'(it.ovf));
            check("tag_wrap", 32'(out_tag_w), 32'(it.tg));
            if (it.lat_chk) check("latency", 32'(cyc - it.hs_cyc), 32'd2);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    send(2'd0, 5'd0, 16'd100, -16'sd30, 4'd1, 1);
    idle();
    wait_drain();
    send(2'd1, 5'd0, 16'h7FFF, 16'hFFFF, 4'd2);
    send(2'd2, 5'd3, 16'd1000, -16'sd512, 4'd3);
    send(2'd3, 5'd15, 16'd0, 16'hFFFF, 4'd4);
    send(2'd2, 5'd20, 16'd5, 16'h8000, 4'd5);
    send(2'd1, 5'd0, 16'd0, 16'h8000, 4'd6);
    send(2'd0, 5'd0, 16'h8000, 16'hFFFF, 4'd7);
    send(2'd3, 5'd16, 16'h7FFF, 16'h8000, 4'd8);
    idle();
    wait_drain();

    // Back-to-back with a 4-cycle downstream stall.
    saw_in_ready_low = 0;
    n_popped = 0;
    fork
      begin
        for (int t = 0; t < 8; t++)
          send(2'(t % 4), 5'(t), 16'(t * 1234), 16'(16'hF000 + t * 97), 4'(t));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_in_ready_low", 32'(saw_in_ready_low), 32'd1);
    check("stall_count", 32'(n_popped), 32'd8);

    // Random traffic with random backpressure.
    rnd_done = 0;
    fork
      begin
        for (int t = 0; t < 40; t++)
          send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        idle();
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two operations held in the pipe.
    out_ready = 1'b0;
    send(2'd0, 5'd0, 16'd11, 16'd22, 4'd10);
    send(2'd0, 5'd0, 16'd33, 16'd44, 4'd11);
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_out_tag", 32'(out_tag), 32'd0);
    check("midrst_wrap_valid", 32'(out_valid_w), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);
    send(2'd1, 5'd0, 16'd500, 16'd123, 4'd12);
    idle();
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
